// File: rtl/sim_vector_gen_if.sv
// Vector stream between the stimulus generator and the circuit under simulation.
// The master drives the vector and its index; the slave returns ready.
interface sim_vector_gen_if #(
    parameter int unsigned WIDTH = 130,
    parameter int unsigned CNT_W = 32
);
    logic [WIDTH-1:0] vec_out;
    logic             vec_valid;
    logic             vec_ready;
    logic [CNT_W-1:0] vec_index;

    modport master (
        output vec_out,
        output vec_valid,
        output vec_index,
        input  vec_ready
    );

    modport slave (
        input  vec_out,
        input  vec_valid,
        input  vec_index,
        output vec_ready
    );
endinterface

// File: rtl/sim_vector_gen.sv
// Stimulus source for a wide combinational circuit: emits a programmed number of vectors
// from an LFSR, walking-one, walking-zero or constant pattern over a valid/ready stream.
module sim_vector_gen #(
    parameter int unsigned WIDTH = 130,
    parameter int unsigned CNT_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_start,
    input  logic                i_abort,
    input  logic [1:0]          i_mode,
    input  logic [WIDTH-1:0]    i_seed,
    input  logic [CNT_W-1:0]    i_num_vectors,
    output logic                o_busy,
    output logic                o_done,
    sim_vector_gen_if.master    vec_if
);

    localparam logic [1:0] ModeLfsr  = 2'b00;
    localparam logic [1:0] ModeWalk1 = 2'b01;
    localparam logic [1:0] ModeWalk0 = 2'b10;

    typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

    state_e           r_state;
    logic [1:0]       r_mode;
    logic [WIDTH-1:0] r_seed;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_vec_out;
    logic             r_vec_valid;
    logic [CNT_W-1:0] r_vec_index;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_first;
    logic [WIDTH-1:0] w_next;
    logic             w_xfer;
    logic             w_last;

    // First vector is built from the live inputs, since mode/seed latch on the same edge.
    always_comb begin
        w_first = i_seed;
        case (i_mode)
            ModeLfsr:  w_first = (i_seed == '0) ? WIDTH'(1) : i_seed;
            ModeWalk1: w_first = WIDTH'(1);
            ModeWalk0: w_first = ~WIDTH'(1);
            default:   w_first = i_seed;
        endcase
    end

    // Walking-zero rotates the inverted pattern, which is the same rotate as walking-one.
    always_comb begin
        w_next = r_seed;
        case (r_mode)
            ModeLfsr:  w_next = {r_vec_out[WIDTH-2:0], r_vec_out[WIDTH-1] ^ r_vec_out[WIDTH-4]};
            ModeWalk1,
            ModeWalk0: w_next = {r_vec_out[WIDTH-2:0], r_vec_out[WIDTH-1]};
            default:   w_next = r_seed;
        endcase
    end

    assign w_xfer = r_vec_valid && vec_if.vec_ready;
    assign w_last = (r_vec_index == r_count - CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_mode      <= '0;
            r_seed      <= '0;
            r_count     <= '0;
            r_vec_out   <= '0;
            r_vec_valid <= 1'b0;
            r_vec_index <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_mode  <= i_mode;
                        r_seed  <= i_seed;
                        r_count <= i_num_vectors;
                        if (i_num_vectors != '0) begin
                            r_state     <= StRun;
                            r_vec_valid <= 1'b1;
                            r_busy      <= 1'b1;
                            r_vec_index <= '0;
                            r_vec_out   <= w_first;
                        end else begin
                            r_state <= StFin;
                            r_done  <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    // Abort wins over a transfer in the same cycle.
                    if (i_abort) begin
                        r_state     <= StIdle;
                        r_vec_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end else if (w_xfer) begin
                        if (w_last) begin
                            r_state     <= StFin;
                            r_vec_valid <= 1'b0;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                        end else begin
                            r_vec_index <= r_vec_index + CNT_W'(1);
                            r_vec_out   <= w_next;
                        end
                    end
                end
                StFin: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state     <= StIdle;
                    r_vec_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign vec_if.vec_out   = r_vec_out;
    assign vec_if.vec_valid = r_vec_valid;
    assign vec_if.vec_index = r_vec_index;
    assign o_busy           = r_busy;
    assign o_done           = r_done;

endmodule

// File: tb/tb_sim_vector_gen.sv
// Scoreboard bench for sim_vector_gen: expected vectors are queued at start and
// popped on every observed transfer.
module tb_sim_vector_gen;

    localparam int unsigned W  = 130;
    localparam int unsigned CW = 32;

    logic          clk;
    logic          rst_n;
    logic          i_start;
    logic          i_abort;
    logic [1:0]    i_mode;
    logic [W-1:0]  i_seed;
    logic [CW-1:0] i_num_vectors;
    logic          o_busy;
    logic          o_done;

    sim_vector_gen_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    sim_vector_gen #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_start       (i_start),
        .i_abort       (i_abort),
        .i_mode        (i_mode),
        .i_seed        (i_seed),
        .i_num_vectors (i_num_vectors),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .vec_if        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0]  exp_vec_q [$];
    logic [CW-1:0] exp_idx_q [$];
    logic [W-1:0]  obs [0:255];
    int xfers, dones, gap;
    logic [W-1:0] one_w;

    task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] m_first(input logic [1:0] m, input logic [W-1:0] sd);
        logic [W-1:0] v;
        v = '0;
        v[0] = 1'b1;
        case (m)
            2'b00:   return (sd == '0) ? v : sd;
            2'b01:   return v;
            2'b10:   return ~v;
            default: return sd;
        endcase
    endfunction

    function automatic logic [W-1:0] m_next(input logic [1:0] m, input logic [W-1:0] s);
        logic [W-1:0] t;
        t = s << 1;
        case (m)
            2'b00: t[0] = s[129] ^ s[126];
            2'b01, 2'b10: t[0] = s[129];
            default: t = s;
        endcase
        return t;
    endfunction

    // Drives start on a negedge; the DUT accepts it at the following posedge.
    task automatic do_start(input logic [1:0] m, input logic [W-1:0] sd, input int n);
        logic [W-1:0] v;
        i_start       = 1'b1;
        i_mode        = m;
        i_seed        = sd;
        i_num_vectors = CW'(n);
        exp_vec_q.delete();
        exp_idx_q.delete();
        v = m_first(m, sd);
        for (int i = 0; i < n; i++) begin
            exp_vec_q.push_back(v);
            exp_idx_q.push_back(CW'(i));
            v = m_next(m, v);
        end
        @(negedge clk);
        i_start = 1'b0;
    endtask

    // stop_kind: 0 none, 1 abort at stop_idx, 2 reset at stop_idx.
    task automatic drain(input int budget, input bit bp, input int stop_idx, input int stop_kind,
                         input int restart_at);
        logic [W-1:0]  pv;
        logic [CW-1:0] pi;
        logic [W-1:0]  ev;
        logic [CW-1:0] ei;
        bit have_prev, prev_rdy, rdy;
        int last;
        xfers = 0; dones = 0; gap = -1; last = -1;
        have_prev = 0; prev_rdy = 1; pv = '0; pi = '0;
        for (int c = 0; c < budget; c++) begin
            if (c == restart_at) begin
                i_start = 1'b1; i_mode = 2'b11; i_num_vectors = 50;
            end else begin
                i_start = 1'b0;
            end
            if (o_done) begin
                dones++;
                gap = c - last;
                bus.vec_ready = 1'b0;
                i_start = 1'b0;
                return;
            end
            if (bus.vec_valid) begin
                if (have_prev && !prev_rdy) begin
                    check_val("hold_vec", bus.vec_out, pv);
                    check_val("hold_idx", W'(bus.vec_index), W'(pi));
                end
                if (stop_kind != 0 && int'(bus.vec_index) == stop_idx) begin
                    if (stop_kind == 1) begin
                        i_abort = 1'b1;
                        bus.vec_ready = 1'b1;
                        @(negedge clk);
                        i_abort = 1'b0;
                    end else begin
                        rst_n = 1'b0;
                        #1;
                    end
                    return;
                end
                rdy = bp ? ((c % 4) == 0 || (c % 4) == 3) : 1'b1;
                bus.vec_ready = rdy;
                if (rdy) begin
                    if (exp_vec_q.size() == 0) begin
                        check_val("sb_empty", W'(1), W'(0));
                    end else begin
                        ev = exp_vec_q.pop_front();
                        ei = exp_idx_q.pop_front();
                        check_val("sb_vec", bus.vec_out, ev);
                        check_val("sb_idx", W'(bus.vec_index), W'(ei));
                    end
                    if (xfers < 256) obs[xfers] = bus.vec_out;
                    xfers++;
                    last = c;
                end
                pv = bus.vec_out; pi = bus.vec_index; have_prev = 1; prev_rdy = rdy;
            end
            @(negedge clk);
        end
        i_start = 1'b0;
        check_val("timeout", W'(0), W'(1));
    endtask

    task automatic check_end(input int n);
        check_val("xfers", W'(xfers), W'(n));
        check_val("dones", W'(dones), W'(1));
        check_val("done_gap", W'(gap), W'(1));
        check_val("sb_left", W'(exp_vec_q.size()), W'(0));
        check_val("fin_valid", W'(bus.vec_valid), W'(0));
        check_val("fin_busy", W'(o_busy), W'(0));
        @(negedge clk);
        check_val("done_width", W'(o_done), W'(0));
    endtask

    initial begin
        one_w = '0;
        one_w[0] = 1'b1;
        rst_n = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_mode = '0; i_seed = '0;
        i_num_vectors = '0; bus.vec_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_vec", bus.vec_out, W'(0));
        check_val("rst_valid", W'(bus.vec_valid), W'(0));
        check_val("rst_idx", W'(bus.vec_index), W'(0));
        check_val("rst_busy", W'(o_busy), W'(0));
        check_val("rst_done", W'(o_done), W'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // LFSR from seed 1
        do_start(2'b00, W'(1), 200);
        check_val("start_busy", W'(o_busy), W'(1));
        drain(1000, 1'b0, -1, 0, -1);
        check_end(200);
        check_val("lfsr_i0", obs[0], one_w);
        check_val("lfsr_i1", obs[1], one_w << 1);
        check_val("lfsr_i126", obs[126], one_w << 126);
        check_val("lfsr_i127", obs[127], (one_w << 127) | one_w);

        do_start(2'b01, '0, 131);
        drain(1000, 1'b0, -1, 0, -1);
        check_end(131);
        check_val("w1_i129", obs[129], one_w << 129);
        check_val("w1_i130", obs[130], one_w);

        do_start(2'b10, '0, 131);
        drain(1000, 1'b0, -1, 0, -1);
        check_end(131);
        check_val("w0_i0", obs[0], ~one_w);
        check_val("w0_i130", obs[130], ~one_w);

        do_start(2'b11, W'(130'h2_dead_beef_0123_4567_89ab_cdef), 6);
        drain(100, 1'b0, -1, 0, -1);
        check_end(6);

        // Backpressure: same sequence as an unstalled run, held during stalls
        do_start(2'b00, W'(5), 24);
        drain(500, 1'b1, -1, 0, -1);
        check_end(24);

        // Zero-length run
        do_start(2'b00, W'(7), 0);
        drain(20, 1'b0, -1, 0, -1);
        check_end(0);

        // Restart while busy must be ignored
        do_start(2'b00, W'(3), 10);
        drain(200, 1'b0, -1, 0, 4);
        check_end(10);

        // Abort together with ready at index 3
        do_start(2'b00, W'(9), 20);
        drain(200, 1'b0, 3, 1, -1);
        check_val("abort_valid", W'(bus.vec_valid), W'(0));
        check_val("abort_busy", W'(o_busy), W'(0));
        check_val("abort_idx", W'(bus.vec_index), W'(3));
        check_val("abort_xfers", W'(xfers), W'(3));
        dones = 0;
        repeat (4) begin
            if (o_done) dones++;
            @(negedge clk);
        end
        check_val("abort_nodone", W'(dones), W'(0));

        do_start(2'b00, '0, 3);
        drain(100, 1'b0, -1, 0, -1);
        check_end(3);
        check_val("zero_seed", obs[0], one_w);

        // Asynchronous reset mid-run
        do_start(2'b01, '0, 100);
        drain(500, 1'b0, 50, 2, -1);
        check_val("mrst_xfers", W'(xfers), W'(50));
        check_val("mrst_vec", bus.vec_out, W'(0));
        check_val("mrst_valid", W'(bus.vec_valid), W'(0));
        check_val("mrst_idx", W'(bus.vec_index), W'(0));
        check_val("mrst_busy", W'(o_busy), W'(0));
        check_val("mrst_done", W'(o_done), W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_start(2'b00, W'(11), 8);
        check_val("post_rst_idx", W'(bus.vec_index), W'(0));
        drain(100, 1'b0, -1, 0, -1);
        check_end(8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
